// File: rtl/fi_campaign_pkg.sv
// Shared types, polynomials and fault-indexing helper for the fault-injection campaign controller.
package fi_campaign_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_EVAL,
        ST_DONE
    } state_t;

    // {A,B} LFSR taps for x^12+x^6+x^4+x+1, Fibonacci form shifting toward the MSB
    localparam logic [11:0] LFSR_TAPS  = 12'h829;
    localparam logic [7:0]  MISR_POLY  = 8'h1D;

    localparam int NUM_LOC    = 8;
    localparam int NUM_TYPE   = 3;
    localparam int NUM_FAULTS = NUM_LOC * NUM_TYPE;

    localparam logic [1:0] F_NONE = 2'b00;

    function automatic logic [4:0] fault_index(input logic [2:0] loc, input logic [1:0] ftype);
        return 5'(loc) * 5'd3 + 5'(ftype) - 5'd1;
    endfunction

endpackage

// File: rtl/fi_misr.sv
// 8-bit multiple-input signature register (x^8+x^4+x^3+x^2+1) with synchronous clear and enable.
module fi_misr
    import fi_campaign_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data,
    output logic [7:0] sig
);

    logic [7:0] sig_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_reg <= 8'h00;
        end else if (clear) begin
            sig_reg <= 8'h00;
        end else if (enable) begin
            sig_reg <= {sig_reg[6:0], 1'b0} ^ (sig_reg[7] ? MISR_POLY : 8'h00) ^ data;
        end
    end

    assign sig = sig_reg;

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Self-test campaign controller: one golden pass plus one pass per fault, LFSR stimulus, MISR compaction.
// Optional signature trace outputs (sig_valid, sig_out) are enabled with FI_SIG_TRACE_EN.
module fault_campaign_ctrl
    import fi_campaign_pkg::*;
#(
    parameter int          N_PATTERNS = 16,
    parameter logic [11:0] LFSR_SEED  = 12'hACE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [7:0]            A,
    output logic [3:0]            B,
    output logic [2:0]            f_loc,
    output logic [1:0]            f_type,
    input  logic [7:0]            Y,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_FAULTS-1:0] detect_map,
    output logic [4:0]            detected_cnt,
    output logic [7:0]            golden_sig
`ifdef FI_SIG_TRACE_EN
    ,
    output logic                  sig_valid,
    output logic [7:0]            sig_out
`endif
);

    localparam logic [7:0] LAST_COUNT = 8'(N_PATTERNS - 1);

    state_t                state_reg, state_next;
    logic [11:0]           lfsr_reg;
    logic [7:0]            count_reg;
    logic [2:0]            loc_reg;
    logic [1:0]            type_reg;
    logic [NUM_FAULTS-1:0] detect_map_reg;
    logic [4:0]            detected_cnt_reg;
    logic [7:0]            golden_reg;

    logic [11:0] lfsr_next;
    logic        misr_clr, misr_en;
    logic [7:0]  misr_sig;
    logic        last_fault, fault_hit;

    assign lfsr_next  = {lfsr_reg[10:0], ^(lfsr_reg & LFSR_TAPS)};
    assign last_fault = (loc_reg == 3'd7) && (type_reg == 2'b11);
    assign fault_hit  = (type_reg != F_NONE) && (misr_sig != golden_reg);

    fi_misr u_misr (
        .clk    (clk),
        .reset  (reset),
        .clear  (misr_clr),
        .enable (misr_en),
        .data   (Y),
        .sig    (misr_sig)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        misr_clr   = 1'b0;
        misr_en    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                    misr_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                misr_en = 1'b1;
                if (count_reg == LAST_COUNT) begin
                    state_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (last_fault) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_RUN;
                    misr_clr   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg         <= 12'h000;
            count_reg        <= 8'h00;
            loc_reg          <= 3'd0;
            type_reg         <= F_NONE;
            detect_map_reg   <= '0;
            detected_cnt_reg <= 5'd0;
            golden_reg       <= 8'h00;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        lfsr_reg         <= LFSR_SEED;
                        count_reg        <= 8'h00;
                        loc_reg          <= 3'd0;
                        type_reg         <= F_NONE;
                        detect_map_reg   <= '0;
                        detected_cnt_reg <= 5'd0;
                        golden_reg       <= 8'h00;
                    end
                end
                ST_RUN: begin
                    lfsr_reg  <= lfsr_next;
                    count_reg <= count_reg + 8'd1;
                end
                ST_EVAL: begin
                    if (type_reg == F_NONE) begin
                        golden_reg <= misr_sig;
                    end else if (fault_hit) begin
                        detect_map_reg[fault_index(loc_reg, type_reg)] <= 1'b1;
                        detected_cnt_reg <= detected_cnt_reg + 5'd1;
                    end
                    // Fault order: golden, then f_loc outer, f_type inner 01..11
                    if (last_fault) begin
                        loc_reg  <= 3'd0;
                        type_reg <= F_NONE;
                    end else begin
                        lfsr_reg  <= LFSR_SEED;
                        count_reg <= 8'h00;
                        if (type_reg == 2'b11) begin
                            loc_reg  <= loc_reg + 3'd1;
                            type_reg <= 2'b01;
                        end else begin
                            type_reg <= type_reg + 2'b01;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FI_SIG_TRACE_EN
    logic       sig_valid_reg;
    logic [7:0] sig_out_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_valid_reg <= 1'b0;
            sig_out_reg   <= 8'h00;
        end else begin
            sig_valid_reg <= (state_reg == ST_EVAL);
            if (state_reg == ST_EVAL) begin
                sig_out_reg <= misr_sig;
            end
        end
    end

    assign sig_valid = sig_valid_reg;
    assign sig_out   = sig_out_reg;
`endif

    assign A            = lfsr_reg[11:4];
    assign B            = lfsr_reg[3:0];
    assign f_loc        = loc_reg;
    assign f_type       = type_reg;
    assign busy         = (state_reg == ST_RUN) || (state_reg == ST_EVAL);
    assign done         = (state_reg == ST_DONE);
    assign detect_map   = detect_map_reg;
    assign detected_cnt = detected_cnt_reg;
    assign golden_sig   = golden_reg;

endmodule
